// File: rtl/cla32.sv
// 32-bit two-level carry-lookahead adder with registered sum and carry-out.
// Eight 4-bit CLA groups feed a second-level lookahead unit that forms every
// group carry-in directly from group generate/propagate and ci.
module cla32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] sum;
    logic        cout;

    // Per-bit generate and propagate.
    always_comb begin
        g = a & b;
        p = a ^ b;
    end

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 8; k++) begin
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Second-level lookahead: each group carry-in is a flat sum of products
    // over lower group G/P and ci, so nothing ripples between groups.
    always_comb begin
        logic term;
        logic acc;
        term = 1'b0;
        acc  = 1'b0;
        grp_c    = '0;
        grp_c[0] = ci;
        for (int k = 1; k <= 8; k++) begin
            acc = 1'b0;
            for (int j = 0; j <= k; j++) begin
                term = (j == 0) ? ci : grp_g[j-1];
                for (int m = j; m < k; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[k] = acc;
        end
    end

    // Internal carries within each group, seeded only by that group's carry-in.
    always_comb begin
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    // Sum bits and final carry (G_all | P_all & ci from the second level).
    always_comb begin
        sum  = p ^ c;
        cout = grp_c[8];
    end

    // Output registers; asynchronous clear drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= 32'h0000_0000;
            co <= 1'b0;
        end else begin
            s  <= sum;
            co <= cout;
        end
    end

endmodule

// File: tb/tb_cla32.sv
// Directed and random checks for cla32: reset behaviour, one-cycle latency,
// carry boundary cases, back-to-back streaming and mid-stream reset.
module tb_cla32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;

    int checks = 0;
    int errors = 0;

    cla32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] es, input logic eco);
        checks++;
        assert ({co, s} === {eco, es}) else begin
            errors++;
            $error("FAIL %s: got co=%0b s=%08h, expected co=%0b s=%08h",
                   tag, co, s, eco, es);
        end
    endtask

    // Drive operands at the falling edge, then check just after the next rising edge.
    task automatic step(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vci, input logic [31:0] es, input logic eco);
        @(negedge clk);
        a  = va;
        b  = vb;
        ci = vci;
        @(posedge clk);
        #1;
        check(tag, es, eco);
    endtask

    logic [32:0] ref_sum;
    logic [31:0] va_t [6];
    logic [31:0] vb_t [6];
    logic        vc_t [6];
    logic [32:0] ve_t [6];

    initial begin
        // Reset asserted with junk on the inputs.
        rst_n = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        ci    = 1'b1;
        #1;
        check("reset_initial", 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'h0, 1'b0);

        // Release with zero operands; first edge loads the current inputs.
        @(negedge clk);
        a     = 32'h0;
        b     = 32'h0;
        ci    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("zero", 32'h0, 1'b0);
        step("zero_ci", 32'h0, 32'h0, 1'b1, 32'h0000_0001, 1'b0);

        step("7s_plus_ones", 32'h7777_7777, 32'hFFFF_FFFF, 1'b0, 32'h7777_7776, 1'b1);
        step("7s_plus_ones_ci", 32'h7777_7777, 32'hFFFF_FFFF, 1'b1, 32'h7777_7777, 1'b1);
        step("alt_prop", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0);
        step("full_prop_ci", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);
        step("cc_double", 32'hCCCC_CCCC, 32'hCCCC_CCCC, 1'b0, 32'h9999_9998, 1'b1);
        step("cc_double_ci", 32'hCCCC_CCCC, 32'hCCCC_CCCC, 1'b1, 32'h9999_9999, 1'b1);
        step("all_ones_ci", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step("group_edge", 32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0);

        // Input changes between edges must not reach the outputs.
        @(negedge clk);
        a  = 32'h0000_0001;
        b  = 32'h0000_0002;
        ci = 1'b0;
        #2;
        check("hold_between_edges", 32'h0000_0010, 1'b0);
        @(posedge clk);
        #1;
        check("after_edge", 32'h0000_0003, 1'b0);

        // Back-to-back operands, one new vector per cycle.
        va_t[0] = 32'h0000_0001; vb_t[0] = 32'h0000_0001; vc_t[0] = 1'b0; ve_t[0] = 33'h0_0000_0002;
        va_t[1] = 32'h8000_0000; vb_t[1] = 32'h8000_0000; vc_t[1] = 1'b0; ve_t[1] = 33'h1_0000_0000;
        va_t[2] = 32'h0FFF_FFFF; vb_t[2] = 32'h0000_0000; vc_t[2] = 1'b1; ve_t[2] = 33'h0_1000_0000;
        va_t[3] = 32'h1234_5678; vb_t[3] = 32'h8765_4321; vc_t[3] = 1'b0; ve_t[3] = 33'h0_9999_9999;
        va_t[4] = 32'hFFFF_0000; vb_t[4] = 32'h0001_0000; vc_t[4] = 1'b1; ve_t[4] = 33'h1_0000_0001;
        va_t[5] = 32'h0000_FFFF; vb_t[5] = 32'h0000_FFFF; vc_t[5] = 1'b1; ve_t[5] = 33'h0_0001_FFFF;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("stream_%0d", i), va_t[i], vb_t[i], vc_t[i],
                 ve_t[i][31:0], ve_t[i][32]);
        end

        // Mid-stream reset between edges while outputs are nonzero.
        step("pre_reset", 32'h7777_7777, 32'hFFFF_FFFF, 1'b1, 32'h7777_7777, 1'b1);
        @(negedge clk);
        a  = 32'h1111_1111;
        b  = 32'h2222_2222;
        ci = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clear", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_ignores_edge", 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_stale", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("first_after_release", 32'h3333_3333, 1'b0);

        // Random operands against a 33-bit reference sum.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, a} + {1'b0, b} + {32'h0, ci};
            @(posedge clk);
            #1;
            check("random", ref_sum[31:0], ref_sum[32]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
